// File: rtl/md_scheduler.sv
// md_scheduler: HI/LO multiply/divide sequencer for the E stage.
// Optional flush abort is compiled in with `define MD_FLUSH_EN.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        d_md_use,
    input  logic        flush,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

`ifdef MD_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_ok;

    logic op_mult, op_multu, op_div, op_divu;
    logic op_mfhi, op_mflo, op_mthi, op_mtlo;
    logic is_mul, is_div, issue_md, kill, last;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        dvs, dvu;
    logic signed [31:0] q_s, r_s;
    logic [31:0]        q_u, r_u;
    logic               dz;
    logic [31:0]        calc_hi, calc_lo;

    // Opcode decode into one-hot strobes
    always_comb begin
        op_mult  = 1'b0;
        op_multu = 1'b0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        op_mfhi  = 1'b0;
        op_mflo  = 1'b0;
        op_mthi  = 1'b0;
        op_mtlo  = 1'b0;
        unique case (1'b1)
            (op == 4'd1): op_mult  = 1'b1;
            (op == 4'd2): op_multu = 1'b1;
            (op == 4'd3): op_div   = 1'b1;
            (op == 4'd4): op_divu  = 1'b1;
            (op == 4'd5): op_mfhi  = 1'b1;
            (op == 4'd6): op_mflo  = 1'b1;
            (op == 4'd7): op_mthi  = 1'b1;
            (op == 4'd8): op_mtlo  = 1'b1;
            default: ;
        endcase
    end

    assign is_mul   = op_mult | op_multu;
    assign is_div   = op_div | op_divu;
    assign issue_md = start & (is_mul | is_div);
    assign kill     = FLUSH_EN & flush;
    assign last     = (cnt == CW'(1));

    // Product/quotient of the issuing operands; a divisor of 1 is
    // substituted for x/0 and for INT_MIN/-1, which yields the required
    // INT_MIN quotient and zero remainder without signed overflow
    always_comb begin
        dz      = (rt == 32'd0);
        prod_s  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
        prod_u  = {32'd0, rs} * {32'd0, rt};
        dvs     = (dz || (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)) ? 32'd1 : rt;
        dvu     = dz ? 32'd1 : rt;
        q_s     = $signed(rs) / $signed(dvs);
        r_s     = $signed(rs) % $signed(dvs);
        q_u     = rs / dvu;
        r_u     = rs % dvu;
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        unique case (1'b1)
            op_mult:  {calc_hi, calc_lo} = prod_s;
            op_multu: {calc_hi, calc_lo} = prod_u;
            op_div: begin
                calc_hi = r_s;
                calc_lo = q_s;
            end
            op_divu: begin
                calc_hi = r_u;
                calc_lo = q_u;
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next-state: issue goes to RUN, last count or flush returns
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (issue_md && !kill) state_nx = RUN;
            RUN:  if (kill || last)      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs and the combinational move-from path
    always_comb begin
        busy     = (state == RUN);
        md_stall = d_md_use & (busy | issue_md);
        result   = 32'd0;
        if (op_mfhi) result = hi;
        if (op_mflo) result = lo;
    end

    // Countdown, pending result capture, HI/LO commit and move-to writes
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_ok <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (kill) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (issue_md) begin
                pend_hi <= calc_hi;
                pend_lo <= calc_lo;
                pend_ok <= ~(is_div & dz);
                cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end
            if (start && op_mthi) hi <= rs;
            if (start && op_mtlo) lo <= rs;
        end else begin
            cnt <= cnt - CW'(1);
            if (last && pend_ok) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

    // An issue while RUN is a hazard-unit bug; it is dropped by the FSM
    ill_start: assert property (@(posedge clk) disable iff (reset)
        !(start && state == RUN));

endmodule
